// File: rtl/buzz_arbiter.sv
// buzz_arbiter
//   Shares one square-wave tone generator between three note requesters
//   (0 = music sequencer, 1 = key-click beeper, 2 = alarm). The highest
//   requesting index wins. A granted note drives tune_time for exactly
//   dur x TICK_CLKS cycles. A higher-priority request pre-empts the note,
//   and every note or abort is followed by GAP_CLKS cycles of silence.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   req[2:0]              note request per requester
//   tune_in0..2 [13:0]    tone period in us, 0 = rest
//   dur_in0..2  [7:0]     note length in 1/16-beat ticks
//   ack/done/aborted[2:0] one-cycle one-hot pulses
//   tune_time[13:0]       period to the tone generator, 0 = silent
//   owner[1:0]            current/last granted requester
//   busy                  high while playing or in the silent gap
module buzz_arbiter #(
   parameter int TICK_CLKS = 1736111,
   parameter int GAP_CLKS  = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [13:0] tune_in0,
   input  logic [13:0] tune_in1,
   input  logic [13:0] tune_in2,
   input  logic [7:0]  dur_in0,
   input  logic [7:0]  dur_in1,
   input  logic [7:0]  dur_in2,
   output logic [2:0]  ack,
   output logic [2:0]  done,
   output logic [2:0]  aborted,
   output logic [13:0] tune_time,
   output logic [1:0]  owner,
   output logic        busy
);
   localparam int TW = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
   localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CLKS - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CLKS - 1);

   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

   state_t            state;
   logic [TW-1:0]     tick_cnt;
   logic [GW-1:0]     gap_cnt;
   logic [7:0]        remain;
   logic              zero_pend;   // zero-length note granted, done due next edge

   logic [2:0][13:0]  tune_v;
   logic [2:0][7:0]   dur_v;
   logic [1:0]        gnt;
   logic              preempt;
   logic              note_end;

   assign tune_v = {tune_in2, tune_in1, tune_in0};
   assign dur_v  = {dur_in2, dur_in1, dur_in0};

   function automatic logic [2:0] onehot(input logic [1:0] i);
      return 3'b001 << i;
   endfunction

   always_comb begin
      gnt = 2'd0;
      if (req[2])      gnt = 2'd2;
      else if (req[1]) gnt = 2'd1;
   end

   // Only requesters strictly above the owner can cut a note short.
   always_comb begin
      preempt = 1'b0;
      case (owner)
         2'd0:    preempt = |req[2:1];
         2'd1:    preempt = req[2];
         default: preempt = 1'b0;
      endcase
   end

   // Last cycle of the last tick: the remaining count hits zero on this edge.
   assign note_end = (tick_cnt == TICK_LAST) && (remain == 8'd1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         ack       <= '0;
         done      <= '0;
         aborted   <= '0;
         tune_time <= '0;
         owner     <= '0;
         busy      <= 1'b0;
         tick_cnt  <= '0;
         gap_cnt   <= '0;
         remain    <= '0;
         zero_pend <= 1'b0;
      end else begin
         ack     <= '0;
         done    <= '0;
         aborted <= '0;
         case (state)
            S_IDLE: begin
               // A zero-length note completes on the edge after its ack;
               // no arbitration happens on that edge.
               if (zero_pend) begin
                  zero_pend <= 1'b0;
                  done      <= onehot(owner);
               end else if (|req) begin
                  ack      <= onehot(gnt);
                  owner    <= gnt;
                  tick_cnt <= '0;
                  if (dur_v[gnt] == 8'd0) begin
                     zero_pend <= 1'b1;
                  end else begin
                     remain    <= dur_v[gnt];
                     tune_time <= tune_v[gnt];
                     busy      <= 1'b1;
                     state     <= S_PLAY;
                  end
               end
            end
            S_PLAY: begin
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt <= '0;
                  remain   <= remain - 8'd1;
               end else begin
                  tick_cnt <= tick_cnt + TW'(1);
               end
               // Normal end takes precedence over a simultaneous pre-empt.
               if (note_end) begin
                  done      <= onehot(owner);
                  tune_time <= '0;
                  gap_cnt   <= '0;
                  state     <= S_GAP;
               end else if (preempt) begin
                  aborted   <= onehot(owner);
                  tune_time <= '0;
                  gap_cnt   <= '0;
                  state     <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/buzz_arbiter.md
# buzz_arbiter

Shares one square-wave tone generator between three note requesters: the music sequencer, the key-click beeper and the alarm. Each requester offers one note at a time, given as a tone period in µs and a duration in 1/16-beat ticks. The arbiter grants the highest-priority requester and drives the generator's period input for exactly the note duration. A higher-priority request pre-empts a playing note, and a short silent gap is inserted between notes so that repeated notes stay audibly separate.

## Interface
Parameters:
- TICK_CLKS, 1736111, clk cycles per 1/16-beat tick (≥1)
- GAP_CLKS, 50000, clk cycles of forced silence after every note or abort (≥1)

Ports:
- clk  in  1  system clock, 50 MHz nominal
- rst  in  1  asynchronous, active-high reset
- req  in  3  note request per requester; bit 2 = alarm (highest priority), bit 0 = music (lowest)
- tune_in0 / tune_in1 / tune_in2  in  14 each  tone period in µs for the matching requester; 0 = rest
- dur_in0 / dur_in1 / dur_in2  in  8 each  note length in ticks
- ack  out  3  one-cycle one-hot pulse: note accepted
- done  out  3  one-cycle pulse: note completed normally
- aborted  out  3  one-cycle pulse: note pre-empted
- tune_time  out  14  period to the tone generator; 0 = silent
- owner  out  2  index of the current/last granted requester
- busy  out  1  high in PLAY and GAP

## Operation
- States: IDLE, PLAY, GAP.
- IDLE: if req != 0, grant the highest set bit i.
  - Latch tune_in[i] and dur_in[i].
  - Pulse ack[i]; set owner to i; clear the tick counter.
  - If dur_in[i] == 0: pulse done[i] on the next cycle, return to IDLE, play no sound and insert no gap.
  - Otherwise, at that same edge, load tune_time with the latched tune and go to PLAY.
- PLAY:
  - The tick counter runs 0..TICK_CLKS-1; the remaining-ticks count decrements on the wrap.
  - When remaining reaches 0: pulse done[owner], set tune_time to 0, go to GAP.
  - Pre-emption: if req[j] is set for any j > owner, pulse aborted[owner], set tune_time to 0, go to GAP.
  - If note end and pre-emption coincide on the same edge, note end wins: done pulses, aborted does not.
  - req bits at or below owner are ignored while in PLAY.
- GAP: tune_time is held at 0 for GAP_CLKS cycles, then the block returns to IDLE. Requests in GAP are not arbitrated; they wait for IDLE.
- Rest notes (tune 0) time out normally with tune_time = 0 and still pulse done.
- Requester rules:
  - Hold req, tune_in and dur_in stable until ack.
  - After ack, drop req within GAP_CLKS cycles, or keep it high with the next note's data presented.
  - req deasserted before ack is a legal withdrawal.
- Widths: tick counter is ceil(log2(TICK_CLKS)) bits; gap counter is ceil(log2(GAP_CLKS)) bits; remaining-ticks count is 8 bits.

## Timing
- All outputs are registered.
- Reset values: tune_time = 0, ack = 0, done = 0, aborted = 0, owner = 0, busy = 0, state = IDLE, all counters = 0.
- Reset mid-note: tune_time goes to 0 immediately (asynchronously). No done or aborted pulse is issued.
- Grant latency: req sampled high in IDLE at edge N → ack, tune_time and busy valid after edge N.
- Note length: tune_time is nonzero for exactly dur × TICK_CLKS cycles.
- done pulses in the first cycle with tune_time = 0.
- Gap: GAP_CLKS cycles. The next grant edge falls one cycle after the gap ends, because IDLE lasts one cycle.
- Pre-emption latency: higher req sampled at edge N → aborted pulse and tune_time = 0 after edge N.
- At most one bit of ack, done or aborted is high in any cycle.

## Test plan
Run all scenarios with TICK_CLKS = 4 and GAP_CLKS = 2.
- Reset: assert rst mid-stream → every output is 0 immediately; after release, state is IDLE with no spurious pulses.
- Single note: req = 001, tune_in0 = 956, dur_in0 = 3 → ack = 001 for 1 cycle; tune_time = 956 for 12 cycles; done = 001 for 1 cycle; tune_time = 0 for 2 cycles; busy then falls.
- Simultaneous requests: req = 011 → requester 1 is granted first; requester 0 is acked 3 cycles after done[1]; owner follows 1 then 0.
- Pre-emption: requester 0 plays dur = 5; req[2] rises on the 6th PLAY cycle → aborted = 001 on the next cycle, done[0] never pulses, 2-cycle gap, then ack = 100.
- Coincident end and pre-empt: req[2] rises on the last tick edge of requester 0's note → done = 001, aborted stays 0.
- Zero-length and rest notes:
  - dur_in0 = 0 → ack, then done on the next cycle; tune_time stays 0; busy stays 0.
  - tune_in0 = 0, dur_in0 = 2 → tune_time stays 0 for 8 cycles, then done pulses.
